uc_secuenciador: RTL and testbench

- Control unit for the 8-bit microcontroller datapath (PC, program memory, register bank, ALU, subroutine return register, relative-jump adder, I/O ports).
- Decodes the 6-bit opcode and drives every datapath select and enable.
- Latches the ALU zero flag and tracks the single-level subroutine return register.
- Sequences an I/O request/acknowledge handshake, stalling the PC through `pc_en`.
- Provides HALT and error reporting. The datapath PC register uses `pc_en` as its load enable.

---
 rtl/uc_secuenciador_if.sv | 34 +++
 rtl/uc_secuenciador.sv | 173 +++++++++++++++++
 tb/tb_uc_secuenciador.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uc_secuenciador_if.sv
// Control bus between the sequencer and the 8-bit microcontroller datapath.
// The master side is the sequencer; the slave side is the datapath / I/O unit.
interface uc_secuenciador_if;
  logic [5:0] opcode;
  logic       z;
  logic       go;
  logic       io_ack;
  logic       pc_en;
  logic       s_inc;
  logic       s_inm;
  logic       we3;
  logic [2:0] op;
  logic       s_subrutina;
  logic       s_ra;
  logic       s_rel;
  logic       s_in;
  logic       s_out;
  logic       out_in;
  logic       io_req;
  logic       halted;
  logic [1:0] err;

  modport master (
    input  opcode, z, go, io_ack,
    output pc_en, s_inc, s_inm, we3, op, s_subrutina, s_ra, s_rel,
           s_in, s_out, out_in, io_req, halted, err
  );

  modport slave (
    output opcode, z, go, io_ack,
    input  pc_en, s_inc, s_inm, we3, op, s_subrutina, s_ra, s_rel,
           s_in, s_out, out_in, io_req, halted, err
  );
endinterface

// File: rtl/uc_secuenciador.sv
// Control unit of the 8-bit microcontroller: decodes the opcode, drives the
// datapath selects, keeps the zero flag and return-register validity, runs
// the I/O request/acknowledge handshake with timeout, and handles HALT.
module uc_secuenciador #(
  parameter int unsigned IO_TIMEOUT = 16,
  parameter int unsigned TW         = 8
) (
  input logic              clk,
  input logic              reset,
  uc_secuenciador_if.master bus
);

  localparam logic [5:0] OP_J    = 6'b001010;
  localparam logic [5:0] OP_JZ   = 6'b011010;
  localparam logic [5:0] OP_JNZ  = 6'b101010;
  localparam logic [5:0] OP_BR   = 6'b001100;
  localparam logic [5:0] OP_BRZ  = 6'b011100;
  localparam logic [5:0] OP_JAL  = 6'b001011;
  localparam logic [5:0] OP_RET  = 6'b011011;
  localparam logic [5:0] OP_IN   = 6'b001001;
  localparam logic [5:0] OP_OUT  = 6'b011001;
  localparam logic [5:0] OP_OUTI = 6'b101001;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [TW-1:0] TMO_LAST = TW'(IO_TIMEOUT - 1);

  // RESUME is the first RUN cycle after HALT: it skips the re-fetched HALT word.
  typedef enum logic [2:0] {BOOT, RUN, IOWAIT, HALT, RESUME} state_t;
  typedef enum logic [1:0] {IO_IN, IO_OUT, IO_OUTI} io_kind_t;

  state_t    state, state_nx;
  io_kind_t  io_kind, io_kind_nx;
  logic      zf, zf_nx;
  logic      ra_valid, ra_valid_nx;
  logic [TW-1:0] tmo, tmo_nx;
  logic [1:0] err_q, err_nx;

  assign bus.err = err_q;

  // State and status registers; reset returns to BOOT and clears all status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BOOT;
      io_kind  <= IO_IN;
      zf       <= 1'b0;
      ra_valid <= 1'b0;
      tmo      <= '0;
      err_q    <= '0;
    end else begin
      state    <= state_nx;
      io_kind  <= io_kind_nx;
      zf       <= zf_nx;
      ra_valid <= ra_valid_nx;
      tmo      <= tmo_nx;
      err_q    <= err_nx;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nx        = state;
    io_kind_nx      = io_kind;
    zf_nx           = zf;
    ra_valid_nx     = ra_valid;
    tmo_nx          = tmo;
    err_nx          = err_q;
    bus.pc_en       = 1'b0;
    bus.s_inc       = 1'b0;
    bus.s_inm       = 1'b0;
    bus.we3         = 1'b0;
    bus.op          = '0;
    bus.s_subrutina = 1'b0;
    bus.s_ra        = 1'b0;
    bus.s_rel       = 1'b0;
    bus.s_in        = 1'b0;
    bus.s_out       = 1'b0;
    bus.out_in      = 1'b0;
    bus.io_req      = 1'b0;
    bus.halted      = 1'b0;

    case (state)
      BOOT: state_nx = RUN;

      RUN: begin
        bus.pc_en = 1'b1;
        bus.s_inc = 1'b1;
        if (!bus.opcode[3]) begin
          bus.op  = bus.opcode[2:0];
          bus.we3 = 1'b1;
          zf_nx   = bus.z;
        end else if (bus.opcode[2:0] == 3'b000) begin
          bus.s_inm = 1'b1;
          bus.we3   = 1'b1;
        end else begin
          case (bus.opcode)
            OP_J:   bus.s_inc = 1'b0;
            OP_JZ:  bus.s_inc = !zf;
            OP_JNZ: bus.s_inc = zf;
            OP_BR:  bus.s_rel = 1'b1;
            OP_BRZ: bus.s_rel = zf;
            OP_JAL: begin
              bus.s_inc       = 1'b0;
              bus.s_subrutina = 1'b1;
              ra_valid_nx     = 1'b1;
              if (ra_valid) err_nx[0] = 1'b1;
            end
            OP_RET: begin
              if (ra_valid) begin
                bus.s_ra    = 1'b1;
                ra_valid_nx = 1'b0;
              end else begin
                err_nx[0] = 1'b1;
              end
            end
            OP_IN, OP_OUT, OP_OUTI: begin
              bus.pc_en  = 1'b0;
              bus.io_req = 1'b1;
              state_nx   = IOWAIT;
              io_kind_nx = (bus.opcode == OP_IN)  ? IO_IN  :
                           (bus.opcode == OP_OUT) ? IO_OUT : IO_OUTI;
            end
            OP_HALT: begin
              bus.pc_en = 1'b0;
              state_nx  = HALT;
            end
            default: ;
          endcase
        end
      end

      // Completion is decided in the same cycle ack/timeout is seen; ack has
      // priority so a coinciding timeout does not flag an error.
      IOWAIT: begin
        if (bus.io_ack || (tmo == TMO_LAST)) begin
          bus.pc_en = 1'b1;
          bus.s_inc = 1'b1;
          tmo_nx    = '0;
          state_nx  = RUN;
          if (!bus.io_ack) err_nx[1] = 1'b1;
          case (io_kind)
            IO_IN: begin
              bus.s_in = 1'b1;
              bus.we3  = 1'b1;
            end
            IO_OUT: bus.s_out = 1'b1;
            IO_OUTI: begin
              bus.s_out  = 1'b1;
              bus.out_in = 1'b1;
            end
            default: ;
          endcase
        end else begin
          bus.io_req = 1'b1;
          tmo_nx     = tmo + TW'(1);
        end
      end

      HALT: begin
        bus.halted = 1'b1;
        if (bus.go) state_nx = RESUME;
      end

      RESUME: begin
        bus.pc_en = 1'b1;
        bus.s_inc = 1'b1;
        state_nx  = RUN;
      end

      default: state_nx = BOOT;
    endcase
  end

endmodule

// File: tb/tb_uc_secuenciador.sv
// Bench for uc_secuenciador: directed walk through the main scenarios, then
// random instruction streams, all compared cycle by cycle to a reference model.
module tb_uc_secuenciador;

  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uc_secuenciador_if bus_if();

  uc_secuenciador #(.IO_TIMEOUT(TMO), .TW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic       pc_en;
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic [2:0] op;
    logic       s_subrutina;
    logic       s_ra;
    logic       s_rel;
    logic       s_in;
    logic       s_out;
    logic       out_in;
    logic       io_req;
    logic       halted;
    logic [1:0] err;
  } outs_t;

  typedef enum int {I_ALU, I_LI, I_J, I_JZ, I_JNZ, I_BR, I_BRZ, I_JAL, I_RET,
                    I_IN, I_OUT, I_OUTI, I_HALT, I_NOP} ins_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: control situation as plain flags and counters.
  bit   m_boot = 1'b1, m_halt = 1'b0, m_resume = 1'b0, m_wait = 1'b0;
  int   m_cnt = 0;
  ins_t m_kind = I_NOP;
  bit   m_zf = 1'b0, m_ra = 1'b0;
  bit [1:0] m_err = 2'b00;

  function automatic ins_t classify(input logic [5:0] o);
    if (!o[3]) return I_ALU;
    if (o[2:0] == 3'b000) return I_LI;
    case (o)
      6'b001010: return I_J;
      6'b011010: return I_JZ;
      6'b101010: return I_JNZ;
      6'b001100: return I_BR;
      6'b011100: return I_BRZ;
      6'b001011: return I_JAL;
      6'b011011: return I_RET;
      6'b001001: return I_IN;
      6'b011001: return I_OUT;
      6'b101001: return I_OUTI;
      6'b111111: return I_HALT;
      default:   return I_NOP;
    endcase
  endfunction

  function automatic outs_t expected();
    outs_t e = '0;
    logic [5:0] o = bus_if.opcode;
    if (!reset) return e;
    e.err = m_err;
    if (m_boot) begin
    end else if (m_halt) begin
      e.halted = 1'b1;
    end else if (m_wait) begin
      if (bus_if.io_ack || m_cnt == int'(TMO) - 1) begin
        e.pc_en = 1'b1;
        e.s_inc = 1'b1;
        if (m_kind == I_IN) begin e.s_in = 1'b1; e.we3 = 1'b1; end
        if (m_kind == I_OUT) e.s_out = 1'b1;
        if (m_kind == I_OUTI) begin e.s_out = 1'b1; e.out_in = 1'b1; end
      end else begin
        e.io_req = 1'b1;
      end
    end else if (m_resume) begin
      e.pc_en = 1'b1;
      e.s_inc = 1'b1;
    end else begin
      e.pc_en = 1'b1;
      e.s_inc = 1'b1;
      case (classify(o))
        I_ALU:  begin e.op = o[2:0]; e.we3 = 1'b1; end
        I_LI:   begin e.s_inm = 1'b1; e.we3 = 1'b1; end
        I_J:    e.s_inc = 1'b0;
        I_JZ:   e.s_inc = !m_zf;
        I_JNZ:  e.s_inc = m_zf;
        I_BR:   e.s_rel = 1'b1;
        I_BRZ:  e.s_rel = m_zf;
        I_JAL:  begin e.s_inc = 1'b0; e.s_subrutina = 1'b1; end
        I_RET:  e.s_ra = m_ra;
        I_IN, I_OUT, I_OUTI: begin e.pc_en = 1'b0; e.io_req = 1'b1; end
        I_HALT: e.pc_en = 1'b0;
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_halt = 1'b0; m_resume = 1'b0; m_wait = 1'b0;
    m_cnt = 0; m_kind = I_NOP; m_zf = 1'b0; m_ra = 1'b0; m_err = 2'b00;
  endtask

  // Advance the model across one rising edge with the inputs that were applied.
  task automatic model_update();
    ins_t k;
    if (!reset) begin model_reset(); return; end
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halt) begin
      if (bus_if.go) begin m_halt = 1'b0; m_resume = 1'b1; end
    end else if (m_wait) begin
      if (bus_if.io_ack || m_cnt == int'(TMO) - 1) begin
        if (!bus_if.io_ack) m_err[1] = 1'b1;
        m_wait = 1'b0;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else if (m_resume) begin
      m_resume = 1'b0;
    end else begin
      k = classify(bus_if.opcode);
      case (k)
        I_ALU: m_zf = bus_if.z;
        I_JAL: begin if (m_ra) m_err[0] = 1'b1; m_ra = 1'b1; end
        I_RET: begin if (m_ra) m_ra = 1'b0; else m_err[0] = 1'b1; end
        I_IN, I_OUT, I_OUTI: begin m_wait = 1'b1; m_cnt = 0; m_kind = k; end
        I_HALT: m_halt = 1'b1;
        default: ;
      endcase
    end
  endtask

  function automatic outs_t sample();
    outs_t s;
    s.pc_en = bus_if.pc_en;   s.s_inc = bus_if.s_inc;   s.s_inm = bus_if.s_inm;
    s.we3 = bus_if.we3;       s.op = bus_if.op;         s.s_subrutina = bus_if.s_subrutina;
    s.s_ra = bus_if.s_ra;     s.s_rel = bus_if.s_rel;   s.s_in = bus_if.s_in;
    s.s_out = bus_if.s_out;   s.out_in = bus_if.out_in; s.io_req = bus_if.io_req;
    s.halted = bus_if.halted; s.err = bus_if.err;
    return s;
  endfunction

  // s_inc only matters while the PC is loading.
  task automatic check_outs(input string tag, input outs_t act);
    outs_t exp = expected();
    outs_t a = act;
    if (!exp.pc_en) begin a.s_inc = 1'b0; exp.s_inc = 1'b0; end
    n_checks++;
    assert (a === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, a, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
    end
  endtask

  // One clock cycle: inputs driven at posedge+1, outputs checked at posedge+4.
  task automatic cycle(input string tag, input logic [5:0] opc, input logic zz,
                       input logic gg, input logic ack, output outs_t o);
    bus_if.opcode = opc;
    bus_if.z      = zz;
    bus_if.go     = gg;
    bus_if.io_ack = ack;
    #3;
    o = sample();
    check_outs(tag, o);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    outs_t o;
    reset = 1'b0;
    model_reset();
    cycle("rst_hold", 6'b000000, 1'b0, 1'b0, 1'b0, o);
    reset = 1'b1;
    cycle("boot", 6'b000000, 1'b0, 1'b0, 1'b0, o);
    check_val("boot_pc_en", {7'b0, o.pc_en}, 8'd0);
  endtask

  logic [5:0] pool [16];

  initial begin
    outs_t o;
    logic [5:0] r_opc;
    bus_if.opcode = '0; bus_if.z = 1'b0; bus_if.go = 1'b0; bus_if.io_ack = 1'b0;
    @(posedge clk); #1;
    cycle("reset0", 6'b000010, 1'b1, 1'b1, 1'b1, o);
    check_val("reset_outs", {o.pc_en, o.we3, o.io_req, o.halted, o.op, 1'b0}, 8'd0);
    reset = 1'b1;
    cycle("boot", 6'b000010, 1'b0, 1'b0, 1'b0, o);
    check_val("boot_pc_en", {7'b0, o.pc_en}, 8'd0);

    // ALU and zero-flag driven branches
    cycle("alu", 6'b000010, 1'b1, 1'b0, 1'b0, o);
    check_val("alu_ctl", {2'b0, o.pc_en, o.s_inc, o.we3, o.op}, 8'b00111010);
    cycle("li", 6'b101000, 1'b0, 1'b0, 1'b0, o);
    check_val("li_inm", {6'b0, o.s_inm, o.we3}, 8'b11);
    cycle("jz_taken", 6'b011010, 1'b0, 1'b0, 1'b0, o);
    check_val("jz_taken_sinc", {7'b0, o.s_inc}, 8'd0);
    cycle("brz_taken", 6'b011100, 1'b0, 1'b0, 1'b0, o);
    cycle("alu_z0", 6'b000001, 1'b0, 1'b0, 1'b0, o);
    cycle("jz_not", 6'b011010, 1'b1, 1'b0, 1'b0, o);
    check_val("jz_not_sinc", {7'b0, o.s_inc}, 8'd1);
    cycle("jnz", 6'b101010, 1'b0, 1'b0, 1'b0, o);
    cycle("br", 6'b001100, 1'b0, 1'b0, 1'b0, o);
    cycle("j", 6'b001010, 1'b0, 1'b0, 1'b0, o);

    // Subroutine return register
    cycle("jal", 6'b001011, 1'b0, 1'b0, 1'b0, o);
    check_val("jal_sub", {7'b0, o.s_subrutina}, 8'd1);
    cycle("ret", 6'b011011, 1'b0, 1'b0, 1'b0, o);
    check_val("ret_sra", {7'b0, o.s_ra}, 8'd1);
    cycle("ret2", 6'b011011, 1'b0, 1'b0, 1'b0, o);
    check_val("ret2_sra", {7'b0, o.s_ra}, 8'd0);
    cycle("nop", 6'b001101, 1'b0, 1'b0, 1'b0, o);
    check_val("ret2_err", {6'b0, o.err}, 8'b01);
    do_reset();
    cycle("jal_a", 6'b001011, 1'b0, 1'b0, 1'b0, o);
    cycle("jal_b", 6'b001011, 1'b0, 1'b0, 1'b0, o);
    cycle("nop", 6'b001101, 1'b0, 1'b0, 1'b0, o);
    check_val("jaljal_err", {6'b0, o.err}, 8'b01);

    // IN with ack on the third wait cycle
    cycle("in", 6'b001001, 1'b0, 1'b0, 1'b0, o);
    check_val("in_req", {6'b0, o.pc_en, o.io_req}, 8'b01);
    cycle("in_w1", 6'b001001, 1'b0, 1'b0, 1'b0, o);
    cycle("in_w2", 6'b001001, 1'b0, 1'b0, 1'b0, o);
    check_val("in_w2_stall", {6'b0, o.pc_en, o.io_req}, 8'b01);
    cycle("in_done", 6'b001001, 1'b0, 1'b0, 1'b1, o);
    check_val("in_done", {4'b0, o.s_in, o.we3, o.pc_en, o.io_req}, 8'b1110);

    // OUTI timeout, then ack coinciding with timeout
    do_reset();
    cycle("outi", 6'b101001, 1'b0, 1'b0, 1'b0, o);
    for (int i = 0; i < 3; i++) cycle("outi_w", 6'b101001, 1'b0, 1'b0, 1'b0, o);
    cycle("outi_tmo", 6'b101001, 1'b0, 1'b0, 1'b0, o);
    check_val("outi_tmo", {5'b0, o.s_out, o.out_in, o.pc_en}, 8'b111);
    cycle("nop", 6'b001101, 1'b0, 1'b0, 1'b0, o);
    check_val("tmo_err", {6'b0, o.err}, 8'b10);
    do_reset();
    cycle("outi", 6'b101001, 1'b0, 1'b0, 1'b0, o);
    for (int i = 0; i < 3; i++) cycle("outi_w", 6'b101001, 1'b0, 1'b0, 1'b0, o);
    cycle("outi_ack_tmo", 6'b101001, 1'b0, 1'b0, 1'b1, o);
    cycle("nop", 6'b001101, 1'b0, 1'b0, 1'b0, o);
    check_val("ack_tmo_err", {6'b0, o.err}, 8'b00);

    // HALT and resume
    cycle("halt", 6'b111111, 1'b0, 1'b0, 1'b0, o);
    check_val("halt_pc_en", {7'b0, o.pc_en}, 8'd0);
    cycle("halted", 6'b111111, 1'b0, 1'b0, 1'b1, o);
    check_val("halted", {6'b0, o.halted, o.pc_en}, 8'b10);
    cycle("halted_go", 6'b111111, 1'b0, 1'b1, 1'b0, o);
    cycle("resume", 6'b111111, 1'b0, 1'b0, 1'b0, o);
    check_val("resume", {5'b0, o.halted, o.pc_en, o.s_inc}, 8'b011);
    cycle("alu_after", 6'b000111, 1'b1, 1'b0, 1'b0, o);

    // Asynchronous reset in the middle of an I/O wait
    cycle("out", 6'b011001, 1'b0, 1'b0, 1'b0, o);
    cycle("out_w1", 6'b011001, 1'b0, 1'b0, 1'b0, o);
    bus_if.io_ack = 1'b0;
    #2;
    check_val("pre_rst_req", {7'b0, bus_if.io_req}, 8'd1);
    reset = 1'b0;
    #1;
    model_reset();
    check_val("async_rst_req", {7'b0, bus_if.io_req}, 8'd0);
    check_outs("async_rst", sample());
    @(posedge clk); model_update(); #1;
    reset = 1'b1;
    cycle("boot_again", 6'b000000, 1'b0, 1'b0, 1'b0, o);

    // Random instruction streams
    pool = '{6'b001010, 6'b011010, 6'b101010, 6'b001100, 6'b011100, 6'b001011,
             6'b011011, 6'b001001, 6'b011001, 6'b101001, 6'b001101, 6'b111111,
             6'b000000, 6'b000101, 6'b011000, 6'b110111};
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0: r_opc = 6'($urandom_range(0, 63));
        1: r_opc = {2'($urandom_range(0, 3)), 1'b0, 3'($urandom_range(0, 7))};
        default: r_opc = pool[$urandom_range(0, 15)];
      endcase
      reset = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      cycle("rand", r_opc, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0), o);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
